// File: rtl/kronos_types.sv
// Shared CSR constants and types for the kronos HPM counter bank.
package kronos_types;

   localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] MHPMEVENT3    = 12'h323;
   localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;

   typedef struct packed {
      logic       of;
      logic       ovfie;
      logic [7:0] sel;
   } mhpmevent_t;

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DONE} rd_state_e;

endpackage

// File: rtl/kronos_hpm_counter.sv
// One HPM counter; 64-bit mode ripples low->high carry through a one-cycle pipeline.
module kronos_hpm_counter #(
   parameter bit EN_64B = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        incr,
   input  logic        ld_lo,
   input  logic        ld_hi,
   input  logic [31:0] ld_data,
   output logic [31:0] count_lo,
   output logic [31:0] count_hi,
   output logic        ovf,
   output logic        count_vld
);

   logic carry_pend;
   logic lo_max;

   assign lo_max = &count_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        count_lo <= '0;
      else if (ld_lo) count_lo <= ld_data;
      else if (incr)  count_lo <= count_lo + 32'd1;
   end

   generate
      if (EN_64B) begin : g_64
         // A pending carry survives a low write but is dropped by a high write.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               carry_pend <= 1'b0;
               count_hi   <= '0;
            end else begin
               carry_pend <= incr & ~ld_lo & lo_max;
               if (ld_hi)           count_hi <= ld_data;
               else if (carry_pend) count_hi <= count_hi + 32'd1;
            end
         end
         assign ovf = carry_pend & ~ld_hi & (&count_hi);
      end else begin : g_32
         logic unused_ld_hi;
         assign unused_ld_hi = ld_hi;
         assign carry_pend   = 1'b0;
         assign count_hi     = '0;
         assign ovf          = incr & ~ld_lo & lo_max;
      end
   endgenerate

   assign count_vld = ~carry_pend;

endmodule

// File: rtl/kronos_hpm_bank.sv
// Bank of mhpmcounter3.. with event selectors, inhibit, overflow flags and read sequencing.
module kronos_hpm_bank
   import kronos_types::*;
#(
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 8,
   parameter bit EN_64B       = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic [11:0]           csr_addr,
   input  logic                  csr_wr_en,
   input  logic [31:0]           csr_wr_data,
   input  logic                  csr_rd_req,
   output logic                  csr_rd_ack,
   output logic [31:0]           csr_rd_data,
   output logic                  csr_hit,
   output logic                  hpm_rd_vld,
   output logic                  lcofi
);

   logic [NUM_COUNTERS-1:0]       inhibit;
   logic [NUM_COUNTERS-1:0]       hit_v;
   logic [NUM_COUNTERS-1:0]       vld_v;
   logic [NUM_COUNTERS-1:0]       irq_v;
   logic [NUM_COUNTERS-1:0][31:0] rd_part;
   logic [255:0]                  ev_ext;
   logic                          sel_inh;
   logic [31:0]                   rd_mux;
   rd_state_e                     state, state_nxt;
   logic                          rd_load;

   // Bit k+1 holds event code k+1, so SEL=0 and SEL>NUM_EVENTS land on zero bits.
   assign ev_ext  = 256'(event_in) << 1;
   assign sel_inh = (csr_addr == MCOUNTINHIBIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        inhibit <= '0;
      else if (csr_wr_en && sel_inh)  inhibit <= csr_wr_data[3 +: NUM_COUNTERS];
   end

   generate
      for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
         localparam logic [11:0] A_EVT = MHPMEVENT3    + 12'(i);
         localparam logic [11:0] A_LO  = MHPMCOUNTER3  + 12'(i);
         localparam logic [11:0] A_HI  = MHPMCOUNTER3H + 12'(i);

         mhpmevent_t  evt;
         logic        sel_evt, sel_lo, sel_hi, wr_evt, ovf, cnt_vld;
         logic [31:0] lo, hi;

         assign sel_evt = (csr_addr == A_EVT);
         assign sel_lo  = (csr_addr == A_LO);
         assign sel_hi  = (csr_addr == A_HI);
         assign wr_evt  = csr_wr_en & sel_evt;

         // Hardware overflow wins over a simultaneous software clear of OF.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               evt <= '0;
            end else begin
               if (wr_evt) begin
                  evt.ovfie <= csr_wr_data[30];
                  evt.sel   <= csr_wr_data[7:0];
                  evt.of    <= csr_wr_data[31] | ovf;
               end else if (ovf) begin
                  evt.of    <= 1'b1;
               end
            end
         end

         kronos_hpm_counter #(.EN_64B(EN_64B)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .incr      (ev_ext[evt.sel] & ~inhibit[i]),
            .ld_lo     (csr_wr_en & sel_lo),
            .ld_hi     (csr_wr_en & sel_hi),
            .ld_data   (csr_wr_data),
            .count_lo  (lo),
            .count_hi  (hi),
            .ovf       (ovf),
            .count_vld (cnt_vld)
         );

         assign hit_v[i]   = sel_evt | sel_lo | sel_hi;
         assign vld_v[i]   = cnt_vld;
         assign irq_v[i]   = evt.of & evt.ovfie;
         assign rd_part[i] = ({32{sel_evt}} & {evt.of, evt.ovfie, 22'b0, evt.sel})
                           | ({32{sel_lo}}  & lo)
                           | ({32{sel_hi}}  & hi);
      end
   endgenerate

   assign csr_hit    = sel_inh | (|hit_v);
   assign hpm_rd_vld = &vld_v;

   always_comb begin
      rd_mux = sel_inh ? (32'(inhibit) << 3) : '0;
      for (int i = 0; i < NUM_COUNTERS; i++) rd_mux = rd_mux | rd_part[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lcofi <= 1'b0;
      else     lcofi <= |irq_v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RD_IDLE;
      else     state <= state_nxt;
   end

   // Data is captured only once no counter has a carry in flight.
   always_comb begin
      state_nxt = state;
      rd_load   = 1'b0;
      case (state)
         RD_IDLE: if (csr_rd_req) state_nxt = RD_WAIT;
         RD_WAIT: if (hpm_rd_vld) begin
            rd_load   = 1'b1;
            state_nxt = RD_DONE;
         end
         RD_DONE: state_nxt = RD_IDLE;
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          csr_rd_data <= '0;
      else if (rd_load) csr_rd_data <= rd_mux;
   end

   assign csr_rd_ack = (state == RD_DONE);

endmodule
